// File: rtl/pipe_ctrl_if.sv
// Stage-status and stage-control bundle between the pipeline traffic controller
// and the interstage registers, fetch unit and performance-counter readers.
interface pipe_ctrl_if;
   logic        if_valid;
   logic        id_valid;
   logic        ex_valid;
   logic        mem_valid;
   logic        wb_valid;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic        id_serialize;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        ex_redirect;
   logic        mem_busy;

   logic        if_advance;
   logic        id_wr_en;
   logic        id_gen_bubble;
   logic        ex_wr_en;
   logic        ex_gen_bubble;
   logic        mem_wr_en;
   logic        mem_gen_bubble;
   logic        wb_wr_en;
   logic        wb_gen_bubble;
   logic [63:0] cycle_cnt;
   logic [63:0] retire_cnt;
   logic [63:0] stall_cnt;

   modport master (
      input  if_valid, id_valid, ex_valid, mem_valid, wb_valid,
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_serialize,
      input  ex_mem_read, ex_rd, ex_redirect, mem_busy,
      output if_advance, id_wr_en, id_gen_bubble, ex_wr_en, ex_gen_bubble,
      output mem_wr_en, mem_gen_bubble, wb_wr_en, wb_gen_bubble,
      output cycle_cnt, retire_cnt, stall_cnt
   );

   modport slave (
      output if_valid, id_valid, ex_valid, mem_valid, wb_valid,
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_serialize,
      output ex_mem_read, ex_rd, ex_redirect, mem_busy,
      input  if_advance, id_wr_en, id_gen_bubble, ex_wr_en, ex_gen_bubble,
      input  mem_wr_en, mem_gen_bubble, wb_wr_en, wb_gen_bubble,
      input  cycle_cnt, retire_cnt, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline traffic controller for the 5-stage in-order core: all stage-advance
// decisions (memory stalls, load-use, redirects, serialization) plus perf counters.
module pipe_ctrl (
   input  logic        clk,
   input  logic        reset,
   pipe_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ISSUE = 2'd2,
      ST_POST  = 2'd3
   } state_t;

   typedef struct packed {
      logic if_adv;
      logic id_wr;
      logic id_bub;
      logic ex_wr;
      logic ex_bub;
      logic mem_wr;
      logic mem_bub;
      logic wb_wr;
      logic wb_bub;
   } ctl_t;

   state_t      state_r;
   state_t      state_nxt_s;
   ctl_t        ctl_s;
   logic        luse_s;
   logic        redir_s;
   logic        pipe_busy_s;
   logic        drain_done_s;
   logic        ser_req_s;
   logic        ser_retire_s;
   logic        stall_s;
   logic [63:0] cycle_cnt_r;
   logic [63:0] retire_cnt_r;
   logic [63:0] stall_cnt_r;

   function automatic ctl_t ctl_reset();
      ctl_t c;
      c         = 9'b0;
      c.id_bub  = 1'b1;
      c.ex_bub  = 1'b1;
      c.mem_bub = 1'b1;
      c.wb_bub  = 1'b1;
      return c;
   endfunction

   // MEM/WB advance normally; callers layer the front-end policy on top.
   function automatic ctl_t ctl_back_adv();
      ctl_t c;
      c        = 9'b0;
      c.mem_wr = 1'b1;
      c.wb_wr  = 1'b1;
      return c;
   endfunction

   function automatic ctl_t ctl_normal(input logic fetch_ok);
      ctl_t c;
      c        = ctl_back_adv();
      c.if_adv = fetch_ok;
      c.id_wr  = 1'b1;
      c.id_bub = ~fetch_ok;
      c.ex_wr  = 1'b1;
      return c;
   endfunction

   function automatic ctl_t ctl_mem_wait();
      ctl_t c;
      c        = 9'b0;
      c.wb_wr  = 1'b1;
      c.wb_bub = 1'b1;
      return c;
   endfunction

   function automatic ctl_t ctl_redirect();
      ctl_t c;
      c        = ctl_back_adv();
      c.if_adv = 1'b1;
      c.id_wr  = 1'b1;
      c.id_bub = 1'b1;
      c.ex_wr  = 1'b1;
      c.ex_bub = 1'b1;
      return c;
   endfunction

   // Hold ID in place and feed EX a bubble (load-use and drain).
   function automatic ctl_t ctl_hold_id();
      ctl_t c;
      c        = ctl_back_adv();
      c.ex_wr  = 1'b1;
      c.ex_bub = 1'b1;
      return c;
   endfunction

   function automatic ctl_t ctl_issue();
      ctl_t c;
      c        = ctl_back_adv();
      c.id_wr  = 1'b1;
      c.id_bub = 1'b1;
      c.ex_wr  = 1'b1;
      return c;
   endfunction

   function automatic ctl_t ctl_post();
      ctl_t c;
      c        = ctl_back_adv();
      c.id_wr  = 1'b1;
      c.id_bub = 1'b1;
      c.ex_wr  = 1'b1;
      c.ex_bub = 1'b1;
      return c;
   endfunction

   // Hazard terms decoded from the stage status.
   always_comb begin
      luse_s = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) & bus.id_valid &
               ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
      redir_s      = bus.ex_valid & bus.ex_redirect;
      pipe_busy_s  = bus.ex_valid | bus.mem_valid | bus.wb_valid;
      // EX is bubbled while draining, so the pipe is empty next cycle once EX and MEM are.
      drain_done_s = ~(bus.ex_valid | bus.mem_valid);
      ser_req_s    = bus.id_valid & bus.id_serialize;
      ser_retire_s = bus.wb_valid & ~bus.ex_valid & ~bus.mem_valid;
      stall_s      = bus.mem_busy | luse_s | (state_r != ST_RUN);
   end

   // Next-state and stage-control decode, highest-priority condition first.
   always_comb begin
      state_nxt_s = state_r;
      ctl_s       = ctl_reset();
      if (!reset) begin
         state_nxt_s = ST_RUN;
         ctl_s       = ctl_reset();
      end else if (bus.mem_busy) begin
         ctl_s = ctl_mem_wait();
      end else if (redir_s) begin
         ctl_s = ctl_redirect();
         case (state_r)
            ST_DRAIN: state_nxt_s = ST_RUN;
            ST_ISSUE: state_nxt_s = ST_POST;
            default:  state_nxt_s = state_r;
         endcase
      end else begin
         case (state_r)
            ST_RUN: begin
               if (ser_req_s) begin
                  if (pipe_busy_s) begin
                     ctl_s       = ctl_hold_id();
                     state_nxt_s = drain_done_s ? ST_ISSUE : ST_DRAIN;
                  end else begin
                     ctl_s       = ctl_issue();
                     state_nxt_s = ST_POST;
                  end
               end else if (luse_s) begin
                  ctl_s = ctl_hold_id();
               end else begin
                  ctl_s = ctl_normal(bus.if_valid);
               end
            end
            ST_DRAIN: begin
               if (pipe_busy_s) begin
                  ctl_s       = ctl_hold_id();
                  state_nxt_s = drain_done_s ? ST_ISSUE : ST_DRAIN;
               end else begin
                  ctl_s       = ctl_issue();
                  state_nxt_s = ST_POST;
               end
            end
            ST_ISSUE: begin
               ctl_s       = ctl_issue();
               state_nxt_s = ST_POST;
            end
            ST_POST: begin
               ctl_s = ctl_post();
               if (ser_retire_s) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_POST;
               end
            end
            default: begin
               ctl_s       = ctl_reset();
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // Drive the stage controls onto the bus.
   always_comb begin
      bus.if_advance     = ctl_s.if_adv;
      bus.id_wr_en       = ctl_s.id_wr;
      bus.id_gen_bubble  = ctl_s.id_bub;
      bus.ex_wr_en       = ctl_s.ex_wr;
      bus.ex_gen_bubble  = ctl_s.ex_bub;
      bus.mem_wr_en      = ctl_s.mem_wr;
      bus.mem_gen_bubble = ctl_s.mem_bub;
      bus.wb_wr_en       = ctl_s.wb_wr;
      bus.wb_gen_bubble  = ctl_s.wb_bub;
      bus.cycle_cnt      = cycle_cnt_r;
      bus.retire_cnt     = retire_cnt_r;
      bus.stall_cnt      = stall_cnt_r;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Performance counters; all wrap silently at 2^64.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt_r  <= 64'd0;
         retire_cnt_r <= 64'd0;
         stall_cnt_r  <= 64'd0;
      end else begin
         cycle_cnt_r <= cycle_cnt_r + 64'd1;
         if (bus.wb_valid) begin
            retire_cnt_r <= retire_cnt_r + 64'd1;
         end
         if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + 64'd1;
         end
      end
   end

endmodule
